servo_pwm_capture: RTL and testbench
====================================

// Module: servo_pwm_capture
// PURPOSE
//  Receive side of the servo PWM link: measures the high time of each servo pulse and recovers the 8-bit commanded angle.
//  Sits on the servo1..servo4 nets, in parallel with the servos, as closed-loop confirmation of PWM_SERVO_CONTROL output.
//  Reports a per-channel angle strobe, a pulse-range error and a loss-of-signal flag; a move-confirm block consumes these.
// PARAMETERS
//  N_CH           4          number of servo channels
//  MIN_TICKS      25_000     high time for angle 0 (0.5 ms @ 50 MHz)
//  TICKS_PER_DEG  556        clk ticks per degree above MIN_TICKS
//  MAX_ANGLE      180        largest legal decoded angle
//  MAX_HIGH       150_000    high time above which the pulse is too long (3 ms)
//  LOST_TICKS     1_250_000  ticks with no rising edge before loss of signal (25 ms)
//  FILT_LEN       8          glitch-filter length; used only with SERVO_CAPTURE_FILTER_EN
// PORTS
//  clk        in   1         system clock
//  rst        in   1         asynchronous, active-low reset
//  pwm_in     in   N_CH      raw servo pulse inputs (asynchronous)
//  angle      out  N_CH x 8  last good decoded angle per channel
//  angle_stb  out  N_CH      1-cycle pulse when angle[ch] is updated
//  angle_vld  out  N_CH      high after the first good pulse; cleared on loss of signal
//  range_err  out  N_CH      1-cycle pulse on a too-short or too-long pulse
//  lost       out  N_CH      level: no rising edge seen for LOST_TICKS
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - all outputs are 0; FSMs go to WAIT_RISE; counters are cleared.
//  Input path: 2-flop synchronizer on pwm_in, then rising/falling edge detect. Edge-to-count latency is 3 clk.
//  Per-channel FSM:
//   - WAIT_RISE: on rise -> HIGH; clear hi_cnt, deg_pre, deg_acc.
//   - HIGH: hi_cnt++ (saturates at MAX_HIGH+1).
//     - Once hi_cnt >= MIN_TICKS, deg_pre counts to TICKS_PER_DEG-1, then wraps to 0 and does deg_acc++.
//     - deg_acc is an unsigned 8-bit count.
//     - Result: angle = floor((hi-MIN_TICKS)/TICKS_PER_DEG).
//     - Any fall -> LOW.
//   - On the fall (evaluated in the cycle the fall is detected):
//     - hi_cnt < MIN_TICKS: range_err=1; angle is held.
//     - hi_cnt > MAX_HIGH or deg_acc > MAX_ANGLE: range_err=1; angle is held.
//     - otherwise: angle<=deg_acc, angle_stb=1, angle_vld=1 on the next cycle.
//   - LOW: on rise -> HIGH, same clears as WAIT_RISE.
//  Loss of signal: a per-channel gap counter is cleared on every rise and increments otherwise (saturating).
//   - At LOST_TICKS: lost=1, angle_vld=0; angle value is retained.
//   - lost clears on the next rise.
//   - A constant-high input also reaches LOST_TICKS; the FSM stays in HIGH and no strobe is produced.
//  Simultaneous events:
//   - Channels are fully independent; all may strobe in the same cycle.
//   - A rise in the same cycle the gap counter reaches LOST_TICKS: the rise wins; lost stays 0.
//  A first pulse already high at reset release is discarded (FSM starts in WAIT_RISE).
//  Reset mid-pulse aborts the measurement; no strobe or error is produced.
// CONFIGURATION
//  SERVO_CAPTURE_FILTER_EN defined:
//   - the synchronized input is passed to edge detect only after it has been stable for FILT_LEN consecutive cycles;
//   - pulses shorter than FILT_LEN are ignored;
//   - latency becomes 3+FILT_LEN clk, equal on both edges, so the measured width is unchanged.
//  Not defined: no filter, latency 3 clk; FILT_LEN is unused.
// STRUCTURE
//  Package servo_pkg: CLK_HZ, the MIN_TICKS/TICKS_PER_DEG/MAX_ANGLE defaults, and typedef angle_t (logic [7:0]).
//   - servo_pkg is shared with the PWM generator so both ends use identical constants.
//  Sub-module servo_pwm_chan: synchronizer, optional filter, FSM, counters and flags for one channel.
//   - The top generates N_CH instances.
// TESTING
//  - Pulse high 75_040 ticks, period 1_000_000 -> angle=90, angle_stb once per period, angle_vld=1, range_err=0.
//  - High 25_000 ticks -> angle=0.
//  - High 125_080 ticks -> angle=180.
//  - High 20_000 ticks after a good 90 -> range_err pulse, angle stays 90, no strobe.
//  - High 160_000 ticks -> range_err pulse, angle held.
//  - Input held low 1_250_000 ticks after good pulses -> lost=1, angle_vld=0; next good pulse -> lost=0 and strobe.
//  - With the filter macro: 3-cycle glitches riding on a 75_040-tick pulse -> angle=90. Without it: glitch split -> range_err.
//  - 4 channels at 0/45/90/180 with coincident falls -> 4 same-cycle strobes with correct angles.
//  - rst asserted mid-pulse -> outputs 0 immediately; no strobe until a full pulse follows.

Source files
------------

// File: rtl/servo_pkg.sv
// Constants and types shared by the servo PWM generator and the servo PWM capture block,
// so that both ends of the link use identical pulse timing.
package servo_pkg;

  localparam int CLK_HZ            = 50_000_000;
  localparam int DEF_MIN_TICKS     = 25_000;
  localparam int DEF_TICKS_PER_DEG = 556;
  localparam int DEF_MAX_ANGLE     = 180;
  localparam int DEF_MAX_HIGH      = 150_000;
  localparam int DEF_LOST_TICKS    = 1_250_000;
  localparam int DEF_FILT_LEN      = 8;

  typedef logic [7:0] angle_t;

  typedef enum logic [1:0] {
    S_WAIT_RISE,
    S_HIGH,
    S_LOW
  } chan_state_e;

endpackage

// File: rtl/servo_pwm_chan.sv
// One servo capture channel: synchronizer, optional glitch filter (SERVO_CAPTURE_FILTER_EN),
// high-time FSM with angle decode, and loss-of-signal detection.
module servo_pwm_chan
  import servo_pkg::*;
#(
  parameter int MIN_TICKS     = DEF_MIN_TICKS,
  parameter int TICKS_PER_DEG = DEF_TICKS_PER_DEG,
  parameter int MAX_ANGLE     = DEF_MAX_ANGLE,
  parameter int MAX_HIGH      = DEF_MAX_HIGH,
  parameter int LOST_TICKS    = DEF_LOST_TICKS,
  parameter int FILT_LEN      = DEF_FILT_LEN
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   pwm_in,
  output angle_t angle,
  output logic   angle_stb,
  output logic   angle_vld,
  output logic   range_err,
  output logic   lost
);

  localparam int HI_W  = $clog2(MAX_HIGH + 2);
  localparam int PRE_W = $clog2(TICKS_PER_DEG + 1);
  localparam int GAP_W = $clog2(LOST_TICKS + 1);

  localparam logic [HI_W-1:0]  MIN_C       = HI_W'(MIN_TICKS);
  localparam logic [HI_W-1:0]  MAX_HIGH_C  = HI_W'(MAX_HIGH);
  localparam logic [PRE_W-1:0] PRE_TOP_C   = PRE_W'(TICKS_PER_DEG - 1);
  localparam angle_t           MAX_ANGLE_C = angle_t'(MAX_ANGLE);
  localparam logic [GAP_W-1:0] LOST_C      = GAP_W'(LOST_TICKS);

  // Edge detect stays off until every stage of the input pipe holds a real sample,
  // so a pulse already high at reset release never looks like a rise.
`ifdef SERVO_CAPTURE_FILTER_EN
  localparam logic [2:0] FILL_DONE = 3'd4;
`else
  localparam logic [2:0] FILL_DONE = 3'd3;
`endif

  logic                sync1_q, sync1_d, sync2_q, sync2_d;
  logic                lvl, lvl_prev_q, lvl_prev_d;
  logic [2:0]          fill_q, fill_d;
  logic                edge_en, rise, fall;
  chan_state_e         state_q, state_d;
  logic [HI_W-1:0]     hi_cnt_q, hi_cnt_d;
  logic [PRE_W-1:0]    deg_pre_q, deg_pre_d;
  angle_t              deg_acc_q, deg_acc_d;
  logic                good_fall, bad_fall;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  angle_t              angle_q, angle_d;
  logic                angle_stb_q, angle_stb_d;
  logic                angle_vld_q, angle_vld_d;
  logic                range_err_q, range_err_d;
  logic                lost_q, lost_d;

  always_comb begin
    sync1_d    = pwm_in;
    sync2_d    = sync1_q;
    lvl_prev_d = lvl;
    fill_d     = (fill_q == FILL_DONE) ? fill_q : fill_q + 3'd1;
  end

`ifdef SERVO_CAPTURE_FILTER_EN
  localparam int FCNT_W = $clog2(FILT_LEN + 1);
  localparam logic [FCNT_W-1:0] FILT_TOP_C = FCNT_W'(FILT_LEN - 1);

  logic              filt_q, filt_d;
  logic [FCNT_W-1:0] filt_cnt_q, filt_cnt_d;

  // The filtered level follows the input only after FILT_LEN consecutive differing samples,
  // which delays both edges equally and leaves the measured width intact.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = filt_cnt_q;
    if (fill_q == 3'd2) begin
      filt_d     = sync2_q;
      filt_cnt_d = '0;
    end else if (sync2_q != filt_q) begin
      if (filt_cnt_q == FILT_TOP_C) begin
        filt_d     = sync2_q;
        filt_cnt_d = '0;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end else begin
      filt_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  assign edge_en = (fill_q == FILL_DONE);
  assign rise    = edge_en & lvl & ~lvl_prev_q;
  assign fall    = edge_en & ~lvl & lvl_prev_q;

  // The rise cycle counts as the first high tick, so hi_cnt equals the pulse width when the fall lands.
  always_comb begin
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    deg_pre_d = deg_pre_q;
    deg_acc_d = deg_acc_q;
    good_fall = 1'b0;
    bad_fall  = 1'b0;
    case (state_q)
      S_WAIT_RISE, S_LOW: begin
        if (rise) begin
          state_d   = S_HIGH;
          hi_cnt_d  = HI_W'(1);
          deg_pre_d = '0;
          deg_acc_d = '0;
        end
      end
      S_HIGH: begin
        if (fall) begin
          state_d = S_LOW;
          if (hi_cnt_q < MIN_C || hi_cnt_q > MAX_HIGH_C || deg_acc_q > MAX_ANGLE_C) begin
            bad_fall = 1'b1;
          end else begin
            good_fall = 1'b1;
          end
        end else if (hi_cnt_q <= MAX_HIGH_C) begin
          hi_cnt_d = hi_cnt_q + 1'b1;
          if (hi_cnt_q >= MIN_C) begin
            if (deg_pre_q == PRE_TOP_C) begin
              deg_pre_d = '0;
              if (deg_acc_q != 8'hFF) begin
                deg_acc_d = deg_acc_q + 1'b1;
              end
            end else begin
              deg_pre_d = deg_pre_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_WAIT_RISE;
    endcase
  end

  // A rise clears the gap counter in the same cycle, so it beats a coincident loss timeout.
  always_comb begin
    gap_cnt_d   = rise ? '0 : ((gap_cnt_q != LOST_C) ? gap_cnt_q + 1'b1 : gap_cnt_q);
    lost_d      = (gap_cnt_d == LOST_C);
    angle_d     = good_fall ? deg_acc_q : angle_q;
    angle_stb_d = good_fall;
    range_err_d = bad_fall;
    angle_vld_d = lost_d ? 1'b0 : (good_fall ? 1'b1 : angle_vld_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      lvl_prev_q  <= 1'b0;
      fill_q      <= '0;
      state_q     <= S_WAIT_RISE;
      hi_cnt_q    <= '0;
      deg_pre_q   <= '0;
      deg_acc_q   <= '0;
      gap_cnt_q   <= '0;
      angle_q     <= '0;
      angle_stb_q <= 1'b0;
      angle_vld_q <= 1'b0;
      range_err_q <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      lvl_prev_q  <= lvl_prev_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      hi_cnt_q    <= hi_cnt_d;
      deg_pre_q   <= deg_pre_d;
      deg_acc_q   <= deg_acc_d;
      gap_cnt_q   <= gap_cnt_d;
      angle_q     <= angle_d;
      angle_stb_q <= angle_stb_d;
      angle_vld_q <= angle_vld_d;
      range_err_q <= range_err_d;
      lost_q      <= lost_d;
    end
  end

  assign angle     = angle_q;
  assign angle_stb = angle_stb_q;
  assign angle_vld = angle_vld_q;
  assign range_err = range_err_q;
  assign lost      = lost_q;

endmodule

// File: rtl/servo_pwm_capture.sv
// Servo PWM receive side: N_CH independent capture channels recovering the commanded angle.
// Define SERVO_CAPTURE_FILTER_EN to add a FILT_LEN-cycle glitch filter on every input.
module servo_pwm_capture
  import servo_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int MIN_TICKS     = DEF_MIN_TICKS,
  parameter int TICKS_PER_DEG = DEF_TICKS_PER_DEG,
  parameter int MAX_ANGLE     = DEF_MAX_ANGLE,
  parameter int MAX_HIGH      = DEF_MAX_HIGH,
  parameter int LOST_TICKS    = DEF_LOST_TICKS,
  parameter int FILT_LEN      = DEF_FILT_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      pwm_in,
  output logic [N_CH-1:0][7:0] angle,
  output logic [N_CH-1:0]      angle_stb,
  output logic [N_CH-1:0]      angle_vld,
  output logic [N_CH-1:0]      range_err,
  output logic [N_CH-1:0]      lost
);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_chan
    servo_pwm_chan #(
      .MIN_TICKS     (MIN_TICKS),
      .TICKS_PER_DEG (TICKS_PER_DEG),
      .MAX_ANGLE     (MAX_ANGLE),
      .MAX_HIGH      (MAX_HIGH),
      .LOST_TICKS    (LOST_TICKS),
      .FILT_LEN      (FILT_LEN)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .pwm_in    (pwm_in[ch]),
      .angle     (angle[ch]),
      .angle_stb (angle_stb[ch]),
      .angle_vld (angle_vld[ch]),
      .range_err (range_err[ch]),
      .lost      (lost[ch])
    );
  end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Directed bench for servo_pwm_capture with timing scaled down (MIN 50, 4 ticks/deg, MAX_HIGH 800, LOST 3000)
// so every scenario fits in a short run; expected angles are worked out by hand from those constants.
module tb_servo_pwm_capture;

  localparam int N_CH   = 4;
  localparam int MIN_T  = 50;
  localparam int TPD    = 4;
  localparam int MAX_A  = 180;
  localparam int MAX_H  = 800;
  localparam int LOST_T = 3000;
  localparam int FILT   = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N_CH-1:0]      pwm_in = '0;
  logic [N_CH-1:0][7:0] angle;
  logic [N_CH-1:0]      angle_stb;
  logic [N_CH-1:0]      angle_vld;
  logic [N_CH-1:0]      range_err;
  logic [N_CH-1:0]      lost;

  int total = 0;
  int bad   = 0;
  int stb_cnt [N_CH];
  int err_cnt [N_CH];
  int all_stb_cnt = 0;

  servo_pwm_capture #(
    .N_CH          (N_CH),
    .MIN_TICKS     (MIN_T),
    .TICKS_PER_DEG (TPD),
    .MAX_ANGLE     (MAX_A),
    .MAX_HIGH      (MAX_H),
    .LOST_TICKS    (LOST_T),
    .FILT_LEN      (FILT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .angle     (angle),
    .angle_stb (angle_stb),
    .angle_vld (angle_vld),
    .range_err (range_err),
    .lost      (lost)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < N_CH; i++) begin
      stb_cnt[i] = 0;
      err_cnt[i] = 0;
    end
  end

  // Pulse outputs are tallied on the falling edge, away from the register updates.
  always @(negedge clk) begin
    for (int ch = 0; ch < N_CH; ch++) begin
      if (angle_stb[ch] === 1'b1) stb_cnt[ch] = stb_cnt[ch] + 1;
      if (range_err[ch] === 1'b1) err_cnt[ch] = err_cnt[ch] + 1;
    end
    if (angle_stb === 4'hF) all_stb_cnt = all_stb_cnt + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hold one channel at a level for n clock edges; called #1 after an edge, returns #1 after an edge.
  task automatic apply_level(input int ch, input logic v, input int n);
    pwm_in[ch] = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int ch, input int hi, input int lo);
    apply_level(ch, 1'b1, hi);
    apply_level(ch, 1'b0, lo);
  endtask

  // All four channels high for their own widths, every pulse ending on the same edge.
  task automatic apply_multi(input int w0, input int w1, input int w2, input int w3, input int lo);
    int w [4];
    int t_max;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    t_max = 0;
    for (int i = 0; i < 4; i++) if (w[i] > t_max) t_max = w[i];
    for (int t = 0; t < t_max; t++) begin
      for (int i = 0; i < 4; i++) pwm_in[i] = (t >= t_max - w[i]);
      @(posedge clk);
      #1;
    end
    pwm_in = '0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  initial begin
    int s0, e0, a0;

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_angle", 32'(angle), 32'd0);
    check_output("rst_flags", {16'd0, angle_stb, angle_vld, range_err, lost}, 32'd0);
    rst = 1'b1;
    apply_level(0, 1'b0, 10);

    s0 = stb_cnt[0]; e0 = err_cnt[0];
    apply_stimulus(0, 410, 200);
    check_output("a90_angle", 32'(angle[0]), 32'd90);
    check_output("a90_stb", stb_cnt[0] - s0, 32'd1);
    check_output("a90_vld", 32'(angle_vld[0]), 32'd1);
    check_output("a90_err", err_cnt[0] - e0, 32'd0);
    apply_stimulus(0, 410, 200);
    check_output("a90_period2_stb", stb_cnt[0] - s0, 32'd2);

    apply_stimulus(0, 50, 200);
    check_output("a0_angle", 32'(angle[0]), 32'd0);
    apply_stimulus(0, 770, 200);
    check_output("a180_angle", 32'(angle[0]), 32'd180);
    apply_stimulus(0, 413, 200);
    check_output("floor_angle", 32'(angle[0]), 32'd90);

    s0 = stb_cnt[0]; e0 = err_cnt[0];
    apply_stimulus(0, 40, 200);
    check_output("short_err", err_cnt[0] - e0, 32'd1);
    check_output("short_hold", 32'(angle[0]), 32'd90);
    apply_stimulus(0, 49, 200);
    check_output("min_edge_err", err_cnt[0] - e0, 32'd2);
    apply_stimulus(0, 774, 200);
    check_output("a181_err", err_cnt[0] - e0, 32'd3);
    apply_stimulus(0, 900, 200);
    check_output("long_err", err_cnt[0] - e0, 32'd4);
    check_output("err_no_stb", stb_cnt[0] - s0, 32'd0);
    check_output("err_hold", 32'(angle[0]), 32'd90);
    check_output("pre_lost", 32'(lost[0]), 32'd0);
    check_output("idle_ch_lost", 32'(lost[3]), 32'd1);

    apply_level(0, 1'b0, LOST_T);
    check_output("lost_set", 32'(lost[0]), 32'd1);
    check_output("lost_vld", 32'(angle_vld[0]), 32'd0);
    check_output("lost_keep_angle", 32'(angle[0]), 32'd90);

    s0 = stb_cnt[0];
    apply_stimulus(0, 410, 200);
    check_output("relock_lost", 32'(lost[0]), 32'd0);
    check_output("relock_stb", stb_cnt[0] - s0, 32'd1);
    check_output("relock_vld", 32'(angle_vld[0]), 32'd1);

    s0 = stb_cnt[0]; e0 = err_cnt[0];
    apply_level(0, 1'b1, 30);
    apply_level(0, 1'b0, 3);
    apply_level(0, 1'b1, 377);
    apply_level(0, 1'b0, 200);
`ifdef SERVO_CAPTURE_FILTER_EN
    check_output("glitch_angle", 32'(angle[0]), 32'd90);
    check_output("glitch_err", err_cnt[0] - e0, 32'd0);
`else
    check_output("glitch_angle", 32'(angle[0]), 32'd81);
    check_output("glitch_err", err_cnt[0] - e0, 32'd1);
`endif
    check_output("glitch_stb", stb_cnt[0] - s0, 32'd1);

    a0 = all_stb_cnt;
    apply_multi(50, 230, 410, 770, 200);
    check_output("multi_same_cycle", all_stb_cnt - a0, 32'd1);
    check_output("multi_ch0", 32'(angle[0]), 32'd0);
    check_output("multi_ch1", 32'(angle[1]), 32'd45);
    check_output("multi_ch2", 32'(angle[2]), 32'd90);
    check_output("multi_ch3", 32'(angle[3]), 32'd180);
    check_output("multi_vld", 32'(angle_vld), 32'hF);
    check_output("multi_lost_clr", 32'(lost[1]), 32'd0);

    s0 = stb_cnt[0]; e0 = err_cnt[0];
    apply_level(0, 1'b1, 200);
    rst = 1'b0;
    #1;
    check_output("midrst_angle", 32'(angle), 32'd0);
    check_output("midrst_flags", {16'd0, angle_stb, angle_vld, range_err, lost}, 32'd0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    apply_level(0, 1'b1, 100);
    apply_level(0, 1'b0, 200);
    check_output("midrst_no_stb", stb_cnt[0] - s0, 32'd0);
    check_output("midrst_no_err", err_cnt[0] - e0, 32'd0);
    apply_stimulus(0, 410, 200);
    check_output("midrst_next_stb", stb_cnt[0] - s0, 32'd1);
    check_output("midrst_next_angle", 32'(angle[0]), 32'd90);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
